// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and
// the parity check helper used by both receive and transmit paths.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // 1 when the received parity bit does not match the data word.
  // Unused upper data bits must be zero.
  function automatic logic par_bad(
    input logic [7:0] data,
    input logic       pbit,
    input logic [1:0] mode
  );
    logic x;
    x = ^data ^ pbit;
    unique case (mode)
      2'(PARITY_ODD):  par_bad = ~x;
      2'(PARITY_EVEN): par_bad = x;
      default:         par_bad = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// RX pin synchroniser plus falling-edge start detector.
// Ports: i_clk, i_rst, i_rx (async) -> o_rx_s (synced), o_start.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_start
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_s;

  // Flops reset to the idle level so reset never fakes a start edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '1;
      prev_s <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
      prev_s <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_rx_s  = sync_q[SYNC_STAGES-1];
  assign o_start = prev_s & ~o_rx_s;

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with error pulses and valid/ready output.
// Ports: i_clk, i_rst, i_rx -> o_data/o_valid (i_ready handshake),
//   o_frame_err, o_parity_err, o_overrun pulses; o_break when
//   UART_RX_BREAK_DETECT_EN is defined.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun
`ifdef UART_RX_BREAK_DETECT_EN
  ,output logic                o_break
`endif
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] SAMPLE =
    CNT_W'(CLK_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(CLK_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT =
    BIT_W'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  logic rx_s, start;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_rx   (i_rx),
    .o_rx_s (rx_s),
    .o_start(start)
  );

  rx_state_t            state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [BIT_W-1:0]     bit_idx, bit_d;
  logic                 stop_idx, stop_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic                 pbad, pbad_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 valid_d, ferr_d, perr_d, ovr_d;
  logic                 commit, tick, wrap;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                 any1, any1_d;
  logic                 bwait, bwait_d;
  logic                 brk_d;
`endif

  assign tick = (cnt == SAMPLE);
  assign wrap = (cnt == LAST);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    bit_d    = bit_idx;
    stop_d   = stop_idx;
    shift_d  = shift;
    pbad_d   = pbad;
    commit   = 1'b0;
    ferr_d   = 1'b0;
    perr_d   = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    any1_d   = any1;
    bwait_d  = bwait;
    brk_d    = 1'b0;
`endif
    if (state != RX_IDLE)
      cnt_d = wrap ? '0 : cnt + 1'b1;
    unique case (state)
      RX_IDLE: begin
`ifdef UART_RX_BREAK_DETECT_EN
        // Hold off after a break until the line returns high.
        if (bwait && rx_s) bwait_d = 1'b0;
        if (start && !bwait) begin
          any1_d = 1'b0;
`else
        if (start) begin
`endif
          state_d = RX_START;
          cnt_d   = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          pbad_d  = 1'b0;
        end
      end
      RX_START: begin
        if (tick && rx_s) state_d = RX_IDLE;
        else if (wrap)    state_d = RX_DATA;
      end
      RX_DATA: begin
        if (tick) begin
          shift_d[bit_idx] = rx_s;
`ifdef UART_RX_BREAK_DETECT_EN
          if (rx_s) any1_d = 1'b1;
`endif
        end
        if (wrap) begin
          if (bit_idx == LAST_BIT)
            state_d = (PARITY != PARITY_NONE) ?
                      RX_PARITY : RX_STOP;
          else
            bit_d = bit_idx + 1'b1;
        end
      end
      RX_PARITY: begin
        if (tick) begin
          pbad_d = par_bad(8'(shift), rx_s, 2'(PARITY));
`ifdef UART_RX_BREAK_DETECT_EN
          if (rx_s) any1_d = 1'b1;
`endif
        end
        if (wrap) state_d = RX_STOP;
      end
      RX_STOP: begin
        if (tick) begin
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = RX_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_d   = !any1;
            bwait_d = !any1;
`endif
          end else if (stop_idx == STOP_LAST) begin
            perr_d  = pbad;
            commit  = !pbad;
            state_d = RX_IDLE;
          end
        end
        if (wrap) stop_d = 1'b1;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Output handshake: a commit while the consumer is taking the old
  // word reloads immediately; otherwise a pending word blocks it.
  always_comb begin
    data_d  = o_data;
    valid_d = o_valid;
    ovr_d   = 1'b0;
    if (o_valid && i_ready) valid_d = 1'b0;
    if (commit) begin
      if (!o_valid || i_ready) begin
        data_d  = shift;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= RX_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      shift        <= '0;
      pbad         <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      any1         <= 1'b0;
      bwait        <= 1'b0;
      o_break      <= 1'b0;
`endif
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      bit_idx      <= bit_d;
      stop_idx     <= stop_d;
      shift        <= shift_d;
      pbad         <= pbad_d;
      o_data       <= data_d;
      o_valid      <= valid_d;
      o_frame_err  <= ferr_d;
      o_parity_err <= perr_d;
      o_overrun    <= ovr_d;
`ifdef UART_RX_BREAK_DETECT_EN
      any1         <= any1_d;
      bwait        <= bwait_d;
      o_break      <= brk_d;
`endif
    end
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised UART receiver, next generation of the team's fixed 8N1 receiver. Adds configurable data width, parity and stop bits, an input synchroniser with falling-edge start detection, per-frame error reporting, and a valid/ready output handshake with overrun detection. Sits between the board RX pin and the command/byte-stream consumer logic.

Parameters:
CLK_PER_BIT, 16, i_clk cycles per bit; legal range is 4 or more.
DATA_BITS, 8, data bits per frame; legal range 5..8.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, legal values 1 or 2.
SYNC_STAGES, 2, synchroniser flops on i_rx; 2 or more.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_rx  in  1  asynchronous serial line; idle high
o_data  out  DATA_BITS  received word, LSB first on the line
o_valid  out  1  o_data holds an unconsumed word
i_ready  in  1  consumer accepts o_data when o_valid && i_ready
o_frame_err  out  1  1-cycle pulse: stop bit sampled low
o_parity_err  out  1  1-cycle pulse: parity mismatch
o_overrun  out  1  1-cycle pulse: good frame dropped because o_valid is still pending
o_break  out  1  only when UART_RX_BREAK_DETECT_EN is defined

Behaviour:
- Reset (synchronous, i_rst=1): state IDLE; o_data=0; o_valid=0; all error pulses and o_break=0; synchroniser flops=1 so reset cannot cause a false start; bit counter and clock counter=0. Reset mid-frame abandons the frame and clears any pending o_data.
- rx_s is i_rx after SYNC_STAGES flops. prev_s is a 1-cycle delayed copy of rx_s. A start edge is prev_s=1 && rx_s=0.
- Clock counter runs 0..CLK_PER_BIT-1 and wraps. The sample point is count == CLK_PER_BIT/2 (integer division). Width is $clog2(CLK_PER_BIT).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a start edge go to START and set count=0. A line held low does not retrigger.
- START: at the sample point, if rx_s=1 this is a false start; return to IDLE with no error pulse. Otherwise continue; at wrap go to DATA.
- DATA: sample at the sample point into shift[bit_idx], bit_idx counting 0..DATA_BITS-1. At wrap after bit DATA_BITS-1, go to PARITY if PARITY!=0, else to STOP.
- PARITY: at the sample point compute par_bad. Odd parity requires XOR(data, bit)=1; even requires 0.
- STOP: sample each stop bit at its sample point.
  - Any stop sample of 0 ends the frame immediately: o_frame_err=1, then IDLE.
  - After the last stop sample is 1: if par_bad, o_parity_err=1; else commit the word. Then go to IDLE at the sample point; do not wait for the bit end.
- Exactly one of frame_err, parity_err, commit or overrun occurs per frame. frame_err has priority over parity_err.
- Commit: if o_valid=0, or o_valid=1 && i_ready=1 in the same cycle, load o_data and set o_valid=1 the next cycle. If o_valid=1 && i_ready=0, drop the word, pulse o_overrun, and leave o_data unchanged.
- Handshake: o_valid clears the cycle after o_valid && i_ready unless a commit coincides. o_data is stable while o_valid=1.
- Latency: o_valid rises 1 cycle after the last stop-bit sample, i.e. SYNC_STAGES + 1 + (frame bits − 0.5)·CLK_PER_BIT cycles after the i_rx falling edge, ±1.

Optional Feature:
UART_RX_BREAK_DETECT_EN
- Defined: o_break pulses for 1 cycle together with o_frame_err when all data bits, and the parity bit if present, were 0. After a break the receiver stays in IDLE until rx_s=1 is seen, then resumes edge detection.
- Undefined: the o_break port and its logic are absent; breaks are reported only as framing errors.

Decomposition:
- Package uart_pkg holds: PARITY_NONE/ODD/EVEN constants, the FSM state typedef (rx_state_t), and a parity helper function shared with the future uart_tx_frame.
- One sub-module, uart_rx_sync: SYNC_STAGES synchroniser, prev_s register and start-edge output.

Test Plan:
- CLK_PER_BIT=8, 8N1, send 0xA5 then 0x3C with i_ready=1 -> o_data=0xA5 then 0x3C, one o_valid each, no error pulses.
- PARITY=2, DATA_BITS=7, send 0x55 with the parity bit flipped -> o_parity_err pulse, o_valid stays 0; correct parity -> o_data=0x55.
- Stop bit driven low on 0x81 -> o_frame_err pulse, no o_valid; a following good 0x42 is received correctly.
- i_ready=0, send 0x11 then 0x22 -> o_data=0x11 held, o_overrun pulses on the 0x22 commit; raise i_ready -> o_valid drops, o_data stays 0x11.
- Glitch low for 2 cycles (< CLK_PER_BIT/2) -> false start, no outputs. i_rst asserted mid-DATA -> o_valid=0, state IDLE, next frame 0x7E received.
- With UART_RX_BREAK_DETECT_EN, hold i_rx low for 2 frames -> a single o_break + o_frame_err pulse, no retrigger until the line goes high.
